// File: rtl/gsim_pkg.sv
// Shared constants, types and helpers for the GSIM residual checker.
package gsim_pkg;

  localparam int unsigned N    = 16;
  localparam int unsigned XW   = 32;
  localparam int unsigned BW   = 16;
  localparam int unsigned AW   = 40;
  localparam int unsigned NTAP = 7;

  // Band coefficients, tap k multiplies column i-3+k.
  localparam int signed COEF [NTAP] = '{-1, 6, -13, 20, -13, 6, -1};

  localparam logic [XW-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [XW-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {StIdle, StLoad, StCalc} gsim_state_e;

  // Clamp a Q24.16 value to the signed Q16.16 range.
  function automatic logic [XW-1:0] sat_q16(input logic signed [AW-1:0] v);
    logic [AW-XW:0] hi;
    hi = v[AW-1:XW-1];
    if ((&hi) || !(|hi)) return v[XW-1:0];
    return v[AW-1] ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/gsim_band_mac.sv
// Shift-add product of one band coefficient and one Q16.16 solution entry.
module gsim_band_mac
  import gsim_pkg::*;
(
  input  logic [XW-1:0]        x_i,
  input  logic [2:0]           tap_i,
  input  logic                 en_i,
  output logic signed [AW-1:0] prod_o
);

  logic signed [AW-1:0] xe;

  // Coefficient decode: 20=16+4, 13=8+4+1, 6=4+2, 1; zero when the tap is off-band.
  always_comb begin
    xe     = {{(AW-XW){x_i[XW-1]}}, x_i};
    prod_o = '0;
    if (en_i) begin
      case (tap_i)
        3'd3:       prod_o = (xe <<< 4) + (xe <<< 2);
        3'd2, 3'd4: prod_o = -((xe <<< 3) + (xe <<< 2) + xe);
        3'd1, 3'd5: prod_o = (xe <<< 2) + (xe <<< 1);
        3'd0, 3'd6: prod_o = -xe;
        default:    prod_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/gsim_residual.sv
// GSIM residual checker: loads b and x, streams r_i = (A*x)_i - b_i for the
// fixed 7-band matrix, one row every 7 cycles, then pulses done.
// Optional squared-error accumulator built when GSIM_SQERR_EN is defined.
module gsim_residual
  import gsim_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          b_valid,
  input  logic [BW-1:0] b_in,
  input  logic          x_valid,
  input  logic [XW-1:0] x_in,
  output logic          r_valid,
  output logic [XW-1:0] r_out,
  output logic [3:0]    r_idx,
  output logic          busy,
  output logic          done,
  output logic [63:0]   sq_err
);

  gsim_state_e          state_q;
  logic [4:0]           bcnt_q, bcnt_d, xcnt_q, xcnt_d;
  logic [2:0]           tap_q;
  logic [3:0]           row_q;
  logic                 run_q;
  logic signed [AW-1:0] acc_q, acc_sum;
  logic signed [AW-1:0] fin_q;
  logic                 fin_v_q;
  logic [3:0]           fin_row_q;
  logic                 r_valid_q, done_q;
  logic [XW-1:0]        r_out_q;
  logic [3:0]           r_idx_q;

  logic [BW-1:0]        b_mem [N];
  logic [XW-1:0]        x_mem [N];

  logic                 b_take, x_take;
  logic [5:0]           col;
  logic                 col_ok;
  logic [XW-1:0]        x_sel;
  logic signed [AW-1:0] prod;
  logic [BW-1:0]        b_sel;
  logic signed [AW-1:0] b_ext, diff;
  logic [XW-1:0]        r_sat;

  // Sample acceptance and the tap/column select for the running row.
  always_comb begin
    b_take = b_valid && (state_q != StCalc) && (bcnt_q != 5'd16);
    x_take = x_valid && (state_q != StCalc) && (xcnt_q != 5'd16);
    bcnt_d = bcnt_q + 5'(b_take);
    xcnt_d = xcnt_q + 5'(x_take);
    // Negative columns wrap to 61..63 and fall out with the >=16 edge columns.
    col    = 6'(row_q) + 6'(tap_q) - 6'd3;
    col_ok = run_q && (state_q == StCalc) && (col < 6'd16);
    x_sel  = x_mem[col[3:0]];
  end

  gsim_band_mac u_mac (
    .x_i    (x_sel),
    .tap_i  (tap_q),
    .en_i   (col_ok),
    .prod_o (prod)
  );

  // Residual of the row finished last cycle, saturated to Q16.16.
  always_comb begin
    acc_sum = acc_q + prod;
    b_sel   = b_mem[fin_row_q];
    b_ext   = {{(AW-BW-16){b_sel[BW-1]}}, b_sel, 16'b0};
    diff    = fin_q - b_ext;
    r_sat   = sat_q16(diff);
  end

  // Sample storage; validity is tracked by the counters, so no reset needed.
  always_ff @(posedge clk) begin
    if (b_take) b_mem[bcnt_q[3:0]] <= b_in;
    if (x_take) x_mem[xcnt_q[3:0]] <= x_in;
  end

  // Control FSM plus MAC pipeline: accumulate taps, then publish one row per 7 cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      bcnt_q    <= '0;
      xcnt_q    <= '0;
      tap_q     <= '0;
      row_q     <= '0;
      run_q     <= 1'b0;
      acc_q     <= '0;
      fin_q     <= '0;
      fin_v_q   <= 1'b0;
      fin_row_q <= '0;
      r_valid_q <= 1'b0;
      r_out_q   <= '0;
      r_idx_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      r_valid_q <= 1'b0;
      done_q    <= 1'b0;
      fin_v_q   <= 1'b0;
      case (state_q)
        StIdle, StLoad: begin
          bcnt_q <= bcnt_d;
          xcnt_q <= xcnt_d;
          if (b_take || x_take) state_q <= StLoad;
          if (bcnt_d == 5'd16 && xcnt_d == 5'd16) begin
            state_q <= StCalc;
            run_q   <= 1'b1;
            tap_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
          end
        end
        StCalc: begin
          if (run_q) begin
            if (tap_q == 3'd6) begin
              // Hand the row off and start the next row's tap 0 with no bubble.
              fin_q     <= acc_sum;
              fin_v_q   <= 1'b1;
              fin_row_q <= row_q;
              acc_q     <= '0;
              tap_q     <= '0;
              row_q     <= row_q + 4'd1;
              if (row_q == 4'd15) run_q <= 1'b0;
            end else begin
              acc_q <= acc_sum;
              tap_q <= tap_q + 3'd1;
            end
          end
          if (fin_v_q) begin
            r_valid_q <= 1'b1;
            r_out_q   <= r_sat;
            r_idx_q   <= fin_row_q;
            if (fin_row_q == 4'd15) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
              bcnt_q  <= '0;
              xcnt_q  <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign r_valid = r_valid_q;
  assign r_out   = r_out_q;
  assign r_idx   = r_idx_q;
  assign done    = done_q;
  assign busy    = (state_q == StCalc);

`ifdef GSIM_SQERR_EN
  logic [63:0]        sq_err_q;
  logic signed [63:0] sq_ext, sq_term;
  logic [64:0]        sq_sum;
  logic [63:0]        sq_acc;

  // Square of the residual being published, added with saturation at all-ones.
  always_comb begin
    sq_ext  = {{32{r_sat[XW-1]}}, r_sat};
    sq_term = sq_ext * sq_ext;
    sq_sum  = {1'b0, sq_err_q} + {1'b0, sq_term};
    sq_acc  = sq_sum[64] ? '1 : sq_sum[63:0];
  end

  // Cleared by the first sample of a frame, then stepped with every residual.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sq_err_q <= '0;
    end else if (state_q == StIdle && (b_take || x_take)) begin
      sq_err_q <= '0;
    end else if (fin_v_q) begin
      sq_err_q <= sq_acc;
    end
  end

  assign sq_err = sq_err_q;
`else
  assign sq_err = '0;
`endif

endmodule

// File: tb/tb_gsim_residual.sv
// Directed bench for gsim_residual with an arithmetic reference model.
module tb_gsim_residual;

  logic        clk = 1'b0;
  logic        reset;
  logic        b_valid;
  logic [15:0] b_in;
  logic        x_valid;
  logic [31:0] x_in;
  logic        r_valid;
  logic [31:0] r_out;
  logic [3:0]  r_idx;
  logic        busy;
  logic        done;
  logic [63:0] sq_err;

  always #5 clk = ~clk;

  gsim_residual dut (
    .clk     (clk),
    .reset   (reset),
    .b_valid (b_valid),
    .b_in    (b_in),
    .x_valid (x_valid),
    .x_in    (x_in),
    .r_valid (r_valid),
    .r_out   (r_out),
    .r_idx   (r_idx),
    .busy    (busy),
    .done    (done),
    .sq_err  (sq_err)
  );

  localparam int signed BAND  [7]  = '{-1, 6, -13, 20, -13, 6, -1};
  localparam int signed BVALS [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_r [16];
  logic [63:0] exp_sq;
  logic signed [31:0] fx [16];
  logic signed [15:0] fb [16];
  int          row_ptr = 0;
  bit          frame_active = 1'b0;
  int          frames_done = 0;
  time         t_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain banded dot product minus b, clamped, plus sum of squares.
  function automatic void build_model();
    logic [64:0] s = '0;
    longint lim_hi = 64'sh7FFF_FFFF;
    longint lim_lo = -(64'sh8000_0000);
    for (int i = 0; i < 16; i++) begin
      longint acc = 0;
      longint sq;
      for (int k = 0; k < 7; k++) begin
        int j = i - 3 + k;
        if (j >= 0 && j < 16) acc += longint'(BAND[k]) * longint'(fx[j]);
      end
      acc -= longint'(fb[i]) * 65536;
      if (acc > lim_hi) acc = lim_hi;
      else if (acc < lim_lo) acc = lim_lo;
      exp_r[i] = acc[31:0];
      sq = acc * acc;
      s = s + {1'b0, sq};
    end
    exp_sq = s[64] ? '1 : s[63:0];
`ifndef GSIM_SQERR_EN
    exp_sq = '0;
`endif
  endfunction

  // Compare process: every published row is checked against the model.
  always @(negedge clk) begin
    if (reset) begin
      if (r_valid) begin
        if (!frame_active) begin
          check("unexpected_r_valid", {63'd0, r_valid}, 64'd0);
        end else begin
          check($sformatf("r_idx_row%0d", row_ptr), 64'(r_idx), 64'(row_ptr));
          check($sformatf("r_out_row%0d", row_ptr), 64'(r_out), 64'(exp_r[row_ptr]));
          check($sformatf("done_row%0d", row_ptr), {63'd0, done}, {63'd0, row_ptr == 15});
          if (row_ptr == 15) begin
            check("done_latency", 64'($time - t_acc), 64'd1135);
            check("sq_err_at_done", sq_err, exp_sq);
            frame_active = 1'b0;
            frames_done++;
          end
          row_ptr++;
        end
      end else if (done) begin
        check("done_without_r_valid", {63'd0, done}, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b_valid = 1'b0;
    x_valid = 1'b0;
    b_in    = '0;
    x_in    = '0;
  endtask

  task automatic arm();
    build_model();
    row_ptr      = 0;
    frame_active = 1'b1;
  endtask

  task automatic send_lockstep();
    for (int i = 0; i < 16; i++) begin
      b_valid = 1'b1;
      b_in    = fb[i];
      x_valid = 1'b1;
      x_in    = fx[i];
      @(posedge clk);
      t_acc = $time;
      #1;
    end
    idle_inputs();
  endtask

  // b block first, three surplus b pulses, then x with random gaps.
  task automatic send_b_then_x();
    for (int i = 0; i < 16; i++) begin
      b_valid = 1'b1;
      b_in    = fb[i];
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      b_in = 16'h7ABC;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      int gap = int'($urandom_range(0, 3));
      repeat (gap) tick();
      x_valid = 1'b1;
      x_in    = fx[i];
      @(posedge clk);
      t_acc = $time;
      #1;
      x_valid = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic wait_frame(input string name);
    int start = frames_done;
    int n = 0;
    while (frames_done == start && n < 400) begin
      tick();
      n++;
    end
    check(name, 64'(frames_done - start), 64'd1);
    frame_active = 1'b0;
    repeat (3) tick();
  endtask

  task automatic load_unit_x(input bit with_b);
    for (int i = 0; i < 16; i++) begin
      fx[i] = 32'sh0001_0000;
      fb[i] = with_b ? 16'(BVALS[i]) : 16'sd0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_r_valid"}, {63'd0, r_valid}, 64'd0);
    check({tag, "_r_out"}, 64'(r_out), 64'd0);
    check({tag, "_r_idx"}, 64'(r_idx), 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_sq_err"}, sq_err, 64'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b1;
    tick();

    // All x = 1.0, b = 0, lockstep.
    load_unit_x(1'b0);
    arm();
    check("model_r0", 64'(exp_r[0]), 64'h000C_0000);
    check("model_r1", 64'(exp_r[1]), 64'hFFFF_0000);
    check("model_r2", 64'(exp_r[2]), 64'h0005_0000);
    check("model_r7", 64'(exp_r[7]), 64'h0004_0000);
    check("model_r15", 64'(exp_r[15]), 64'h000C_0000);
`ifdef GSIM_SQERR_EN
    check("model_sq", exp_sq, 64'h0000_01F4_0000_0000);
`endif
    send_lockstep();
    repeat (20) tick();
    check("busy_in_calc", {63'd0, busy}, 64'd1);
    wait_frame("frame_lockstep");
    check("busy_after_done", {63'd0, busy}, 64'd0);
    check("sq_err_held", sq_err, exp_sq);

    // b chosen to cancel A*x exactly.
    load_unit_x(1'b1);
    arm();
    check("model_zero_r0", 64'(exp_r[0]), 64'd0);
    check("model_zero_sq", exp_sq, 64'd0);
    send_lockstep();
    wait_frame("frame_zero");

    // One large x entry drives saturation on the near-band rows.
    for (int i = 0; i < 16; i++) begin
      fx[i] = '0;
      fb[i] = '0;
    end
    fx[0] = 32'sh7FFF_0000;
    arm();
    check("model_sat_r0", 64'(exp_r[0]), 64'h7FFF_FFFF);
    check("model_sat_r1", 64'(exp_r[1]), 64'h8000_0000);
    check("model_sat_r2", 64'(exp_r[2]), 64'h7FFF_FFFF);
    check("model_sat_r3", 64'(exp_r[3]), 64'h8001_0000);
    check("model_sat_r4", 64'(exp_r[4]), 64'd0);
    send_lockstep();
    wait_frame("frame_sat");

    // b then x with gaps, extras in LOAD and junk during CALC.
    load_unit_x(1'b0);
    arm();
    send_b_then_x();
    for (int i = 0; i < 20; i++) begin
      b_valid = 1'b1;
      b_in    = 16'(i * 37);
      x_valid = 1'b1;
      x_in    = 32'h1234_0000 + 32'(i);
      tick();
    end
    idle_inputs();
    wait_frame("frame_interleaved");
    check("busy_after_interleaved", {63'd0, busy}, 64'd0);

    // Reset pulse while row 7 is being computed.
    load_unit_x(1'b0);
    arm();
    send_lockstep();
    repeat (52) tick();
    frame_active = 1'b0;
    check("rows_before_reset", 64'(row_ptr), 64'd7);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_outputs_zero("midreset");
    repeat (150) tick();
    check("no_done_after_reset", 64'(frames_done), 64'd4);

    // Fresh frame reproduces the first scenario.
    arm();
    send_lockstep();
    wait_frame("frame_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
